vga_pixel_fifo: RTL

Pixel buffer stage directly upstream of the 2-bit-per-channel VGA output/timing stage. A producer (pattern generator or Avalon-side frame reader) pushes 6-bit pixels through a valid/ready handshake. The FIFO pops one pixel per clock while the VGA timing stage reports active video, drives registered R/G/B, and realigns to the producer at every frame start. Underflow is detected, flagged, and replaced by a defined fill colour.

---
 rtl/vga_pixel_fifo.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/vga_pixel_fifo.sv
// vga_pixel_fifo: pixel buffer feeding the 2-bit-per-channel VGA output stage.
// A producer pushes 6-bit {R,G,B} pixels via valid/ready; while the timing
// stage reports active video (Blank=1) one pixel is popped per clock onto
// registered R/G/B. Every Vs falling edge empties the buffer and pulses
// frame_start so the producer restarts at pixel 0 of the frame.
// Optional build macro: VGA_PIXEL_FIFO_UNDERFLOW_FILL_EN
//   defined     -> underflow pixels are magenta (R=3, G=0, B=3)
//   not defined -> underflow pixels are black
// AW must equal log2(DEPTH); DEPTH is a power of two in 4..1024.

module vga_pixel_fifo #(
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic [5:0]    wr_data,
   input  logic          wr_valid,
   output logic          wr_ready,
   output logic          frame_start,
   input  logic          Vs,
   input  logic          Blank,
   output logic [1:0]    R,
   output logic [1:0]    G,
   output logic [1:0]    B,
   output logic [AW:0]   level,
   output logic          underflow
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

`ifdef VGA_PIXEL_FIFO_UNDERFLOW_FILL_EN
   localparam logic [5:0] C_FILL_PIX = 6'b11_00_11;
`else
   localparam logic [5:0] C_FILL_PIX = 6'b00_00_00;
`endif

   state_t        r_state;
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_level;
   logic          r_underflow;
   logic          r_vs_q;
   logic [5:0]    r_rgb;
   logic [5:0]    r_mem [DEPTH];

   logic w_vs_fall;
   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop_slot;
   logic w_pop;
   logic w_underrun;

   // Frame restart detect: Vs is active-low, so a fall marks a new frame.
   assign w_vs_fall   = r_vs_q & ~Vs;
   assign w_full      = (r_level == C_FULL);
   assign w_empty     = (r_level == '0);

   // Ready is suppressed on the restart cycle so the cleared pointers never
   // race a write that would otherwise be lost or double-counted.
   assign wr_ready    = (r_state != ST_IDLE) && !w_full && !w_vs_fall;
   assign w_push      = wr_valid & wr_ready;

   // A pop slot exists on every active-video cycle in RUN; with the buffer
   // empty it becomes an underrun. level is the registered occupancy, so a
   // push in the same cycle is never visible to this pop (no bypass path).
   assign w_pop_slot  = (r_state == ST_RUN) && Blank && !w_vs_fall;
   assign w_pop       = w_pop_slot & ~w_empty;
   assign w_underrun  = w_pop_slot & w_empty;

   assign frame_start = w_vs_fall;
   assign level       = r_level;
   assign underflow   = r_underflow;
   assign R           = r_rgb[5:4];
   assign G           = r_rgb[3:2];
   assign B           = r_rgb[1:0];

   // Control: state machine, pointers, occupancy and the sticky underflow flag.
   // NOTE: all state here uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours, matching the hardware.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_underflow <= 1'b0;
         r_vs_q      <= 1'b1;
      end else begin
         r_vs_q <= Vs;
         if (w_vs_fall) begin
            r_state     <= ST_FILL;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_underflow <= 1'b0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
               2'b10:   r_level <= r_level + (AW+1)'(1);
               2'b01:   r_level <= r_level - (AW+1)'(1);
               default: r_level <= r_level;
            endcase
            if (w_underrun) r_underflow <= 1'b1;
            case (r_state)
               ST_FILL: if (w_full || Blank) r_state <= ST_RUN;
               default: r_state <= r_state;
            endcase
         end
      end
   end

   // Pixel storage write port.
   // NOTE: the storage array has no reset; its contents are don't-care until
   // written, and leaving it out of reset lets it map onto RAM.
   always_ff @(posedge clock) begin
      if (w_push) r_mem[r_wr_ptr] <= wr_data;
   end

   // Registered colour output: popped pixel, fill colour on underrun, else black.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_rgb <= '0;
      end else if (w_pop) begin
         r_rgb <= r_mem[r_rd_ptr];
      end else if (w_underrun) begin
         r_rgb <= C_FILL_PIX;
      end else begin
         r_rgb <= '0;
      end
   end

endmodule
